// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light phase interface: phase codes,
// 7-segment encodings and the converter state type.
package traffic_pkg;

  localparam logic [1:0] PH_OFF     = 2'd0;
  localparam logic [1:0] PH_LEFT    = 2'd1;
  localparam logic [1:0] PH_FORWARD = 2'd2;
  localparam logic [1:0] PH_RIGHT   = 2'd3;

  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [7:0] DISPLAY_MAX = 8'd99;

  // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic [1:0] {
    CV_IDLE   = 2'd0,
    CV_SHIFT  = 2'd1,
    CV_COMMIT = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    if (digit > 4'd9) return SEG_BLANK;
    return SEG_TABLE[digit];
  endfunction

  function automatic logic [7:0] saturate_display(input logic [31:0] value);
    return (value > 32'(DISPLAY_MAX)) ? DISPLAY_MAX : value[7:0];
  endfunction

endpackage

// File: rtl/traffic_display_driver_bin2bcd.sv
// Serial 8-bit double-dabble converter: one add-3/shift iteration per cycle,
// result registered into tens/units when the iterations are done.
module bin2bcd_seq
  import traffic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] units
);

  conv_state_t state_reg, state_next;
  logic [19:0] sr_reg, sr_next, sr_adj;   // {hundreds, tens, units, binary}
  logic [3:0]  iter_reg, iter_next;
  logic [3:0]  tens_next, units_next;

  assign sr_adj[7:0] = sr_reg[7:0];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adjust
      always_comb begin
        sr_adj[8 + 4*gi +: 4] = sr_reg[8 + 4*gi +: 4];
        if (sr_reg[8 + 4*gi +: 4] >= 4'd5)
          sr_adj[8 + 4*gi +: 4] = sr_reg[8 + 4*gi +: 4] + 4'd3;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= CV_IDLE;
      sr_reg    <= '0;
      iter_reg  <= '0;
      tens      <= '0;
      units     <= '0;
    end else begin
      state_reg <= state_next;
      sr_reg    <= sr_next;
      iter_reg  <= iter_next;
      tens      <= tens_next;
      units     <= units_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    iter_next  = iter_reg;
    tens_next  = tens;
    units_next = units;
    case (state_reg)
      CV_SHIFT: begin
        // After eight shifts the result is latched as we enter COMMIT, so the
        // new digits are visible for the whole COMMIT cycle.
        if (iter_reg == 4'd8) begin
          state_next = CV_COMMIT;
          tens_next  = sr_reg[15:12];
          units_next = sr_reg[11:8];
        end else begin
          sr_next   = sr_adj << 1;
          iter_next = iter_reg + 4'd1;
        end
      end
      default: begin
        if (start) begin
          state_next = CV_SHIFT;
          sr_next    = {12'd0, bin};
          iter_next  = 4'd0;
        end else begin
          state_next = CV_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    busy = (state_reg != CV_IDLE);
    done = (state_reg == CV_COMMIT);
  end

endmodule

// File: rtl/traffic_display_driver.sv
// Lamp decode, multiplexed two-digit countdown display and stale-input
// watchdog for the traffic-light phase interface.
module traffic_display_driver
  import traffic_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 25000000,
  parameter int unsigned TIMEOUT   = 100000000,
  parameter int unsigned WARN_SECS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [1:0]  phase,
  input  logic [31:0] count,
  output logic        lamp_red,
  output logic        lamp_yellow,
  output logic        lamp_green,
  output logic        lamp_left,
  output logic        lamp_right,
  output logic [6:0]  seg_n,
  output logic [1:0]  dig_n,
  output logic        busy,
  output logic        fault
);

  localparam logic [31:0] SCAN_LAST  = SCAN_DIV - 1;
  localparam logic [31:0] BLINK_LAST = BLINK_DIV - 1;
  localparam logic [31:0] WD_LAST    = TIMEOUT - 1;
  localparam logic [31:0] WARN_LIMIT = WARN_SECS;

  logic [1:0]  cur_phase_reg;
  logic [31:0] cur_count_reg;
  logic [31:0] scan_cnt_reg, blink_cnt_reg, wd_cnt_reg;
  logic        digit_sel_reg;   // 0 = units, 1 = tens
  logic        blink_reg;
  logic        pend_valid_reg;
  logic [7:0]  pend_value_reg;

  logic        conv_busy, conv_done, conv_start;
  logic [7:0]  tick_value, conv_value;
  logic [3:0]  bcd_tens, bcd_units;

  assign tick_value = saturate_display(count);

  // A tick can start the converter when it is idle or finishing; otherwise
  // it parks in the pending slot and is launched straight out of COMMIT.
  assign conv_start = tick ? (!conv_busy || conv_done) : (conv_done && pend_valid_reg);
  assign conv_value = tick ? tick_value : pend_value_reg;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (conv_value),
    .busy  (conv_busy),
    .done  (conv_done),
    .tens  (bcd_tens),
    .units (bcd_units)
  );

  assign busy  = conv_busy;
  assign fault = (wd_cnt_reg == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_phase_reg  <= PH_OFF;
      cur_count_reg  <= '0;
      pend_valid_reg <= 1'b0;
      pend_value_reg <= '0;
    end else begin
      if (tick) begin
        cur_phase_reg <= phase;
        cur_count_reg <= count;
      end
      if (tick && conv_busy && !conv_done) begin
        pend_valid_reg <= 1'b1;
        pend_value_reg <= tick_value;
      end else if (conv_start) begin
        pend_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt_reg  <= '0;
      digit_sel_reg <= 1'b0;
      blink_cnt_reg <= '0;
      blink_reg     <= 1'b1;
      wd_cnt_reg    <= '0;
    end else begin
      if (scan_cnt_reg == SCAN_LAST) begin
        scan_cnt_reg  <= '0;
        digit_sel_reg <= ~digit_sel_reg;
      end else begin
        scan_cnt_reg <= scan_cnt_reg + 32'd1;
      end
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg <= '0;
        blink_reg     <= ~blink_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 32'd1;
      end
      if (tick)
        wd_cnt_reg <= '0;
      else if (wd_cnt_reg != WD_LAST)
        wd_cnt_reg <= wd_cnt_reg + 32'd1;
    end
  end

  always_comb begin
    lamp_red    = 1'b0;
    lamp_yellow = 1'b0;
    lamp_green  = 1'b0;
    lamp_left   = 1'b0;
    lamp_right  = 1'b0;
    if (fault) begin
      lamp_yellow = blink_reg;
    end else begin
      case (cur_phase_reg)
        PH_OFF: begin
          lamp_red    = 1'b1;
          lamp_yellow = (cur_count_reg != 32'd0);
        end
        PH_LEFT: begin
          lamp_red  = 1'b1;
          lamp_left = 1'b1;
        end
        PH_FORWARD: begin
          lamp_green = (cur_count_reg <= WARN_LIMIT) ? blink_reg : 1'b1;
        end
        default: begin
          lamp_red   = 1'b1;
          lamp_right = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    dig_n = digit_sel_reg ? 2'b01 : 2'b10;
    seg_n = seg_encode(digit_sel_reg ? bcd_tens : bcd_units);
    if (fault || (cur_phase_reg == PH_OFF && cur_count_reg == 32'd0) ||
        (digit_sel_reg && bcd_tens == 4'd0))
      seg_n = SEG_BLANK;
  end

endmodule

// File: doc/traffic_display_driver.md
# traffic_display_driver

Consumer side of the traffic-light phase interface. Takes the 2-bit phase code and 32-bit countdown from the sequence generator and drives the physical lamp outputs plus a two-digit multiplexed 7-segment countdown display. Contains a sequential binary-to-BCD converter, scan and blink timers, and a stale-input watchdog. All logic runs on one clock and reset; the generator's outputs reach it as same-domain signals qualified by `tick`.

## Interface
- `SCAN_DIV`, 50000: clk cycles per digit during display scanning.
- `BLINK_DIV`, 25000000: clk cycles per blink half-period.
- `TIMEOUT`, 100000000: clk cycles without `tick` before fault.
- `WARN_SECS`, 3: green blinks when FORWARD count is at or below this value.

- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high. Clock is clk.
- `tick` in 1: one-cycle pulse; phase/count are valid and new.
- `phase` in 2: 0 OFF (yellow/all-stop), 1 LEFT, 2 FORWARD, 3 RIGHT.
- `count` in 32: remaining seconds, unsigned.
- `lamp_red`, `lamp_yellow`, `lamp_green`, `lamp_left`, `lamp_right` out 1 each: active-high lamps.
- `seg_n` out 7: {g,f,e,d,c,b,a}, active-low.
- `dig_n` out 2: [0] units, [1] tens, active-low.
- `busy` out 1: BCD conversion in progress.
- `fault` out 1: watchdog expired.

## Operation
- On `tick`, latch phase into `cur_phase` and count into `cur_count`. Lamps decode from `cur_phase`.
- Lamp decode when not in fault:
  - OFF: red=1. Yellow=1 if cur_count≠0, otherwise yellow=0.
  - LEFT: red=1, left=1.
  - FORWARD: green=1. If cur_count≤WARN_SECS, green follows `blink`.
  - RIGHT: red=1, right=1.
  - All lamps not listed are 0.
- Saturation: the value for display is min(count,99), held as 8 bits.
- Converter FSM:
  - States IDLE → SHIFT → COMMIT → IDLE.
  - SHIFT runs exactly 8 double-dabble iterations (add 3 to any nibble ≥5, then shift).
  - COMMIT copies the BCD result into the display registers `tens`/`units`.
  - `busy`=1 in SHIFT and COMMIT.
- `tick` while busy:
  - Value goes into a one-deep pending register; a newer tick overwrites it.
  - Lamps still update immediately.
  - After COMMIT, the FSM restarts from the pending value.
- Blanking:
  - Tens digit is blank when tens=0.
  - Both digits are blank when cur_phase=OFF and cur_count=0.
  - Blank means seg_n=7'h7F.
- Scan: a divider toggles the active digit every SCAN_DIV cycles. dig_n alternates 2'b10 / 2'b01 and is never 2'b00.
- Blink: a free-running divider toggles `blink` every BLINK_DIV cycles.
- Watchdog:
  - Counter clears on `tick`. `fault` sets when it reaches TIMEOUT-1.
  - In fault: only the yellow lamp is driven, and it follows `blink`. Both digits are blank.
  - The next `tick` clears fault in the same edge and is processed normally.

## Timing
- Reset values:
  - Outputs: lamp_red=1, all other lamps 0, seg_n=7'h7F, dig_n=2'b10, busy=0, fault=0.
  - Internal: cur_phase=OFF, cur_count=0, blink=1, all dividers 0, FSM IDLE, pending empty.
- Lamp latency: tick sampled at edge 0 → lamps reflect the new phase after edge 0.
- Digit latency: tick at edge 0 → SHIFT at edges 1–8 → COMMIT at edge 9. New digits appear on seg_n after edge 9 (10-cycle latency). `busy` is high from after edge 0 through edge 9.
- Back-to-back: a pending value starts SHIFT at edge 10.
- Reset asserted mid-conversion aborts immediately and returns to reset values. Pending and partial results are discarded.
- Scan and blink dividers wrap at DIV-1 → 0.
- Watchdog saturates in fault and does not wrap.

## Structure
- Shared package `traffic_pkg`:
  - phase localparams PH_OFF/PH_LEFT/PH_FORWARD/PH_RIGHT (also used by the sequence generator).
  - 7-segment constant table for digits 0–9.
  - SEG_BLANK.
- Sub-module `bin2bcd_seq`: 8-bit serial double-dabble with start/busy/done and a 2-digit BCD output. The top level holds the lamp decode, the pending register, the dividers and the watchdog.

## Test plan
- Reset, then tick phase=2, count=15:
  - green=1, red=0.
  - After 10 cycles, units=5 shows seg_n=7'b0010010, tens=1 shows 7'b1111001.
  - busy high for exactly 10 cycles.
- tick phase=2, count=3: green toggles every BLINK_DIV cycles (run with small BLINK_DIV). Then tick count=4: green steady.
- tick count=250 → display 99. tick count=7 → tens blank, units 7'b1111000. tick phase=0, count=0 → both digits blank, red=1, yellow=0.
- Ticks with count 20, 30, 40 on consecutive cycles: lamps track each tick; final display 40. The intermediate 30 is never committed; 20 commits first.
- No tick for TIMEOUT cycles: fault=1, only yellow blinks, digits blank. Next tick phase=1, count=10: fault=0, left=1, red=1, display 10.
- Assert reset at SHIFT iteration 4: all outputs at reset values the next cycle, busy=0, no stale commit afterwards.
